instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port im_req  output  1  instruction-memory read request, one-cycle pulse.
REQ-005 SHALL have port im_addr  output  32  word address for im_req, bits[1:0] always 2'b00.
REQ-006 SHALL have port im_rvalid  input  1  read data valid, one cycle, one response per request.
REQ-007 SHALL have port im_rdata  input  32  instruction word, valid with im_rvalid.
REQ-008 SHALL have port instr  output  32  head-of-buffer instruction to the decoder.
REQ-009 SHALL have port instr_pc  output  32  PC of instr.
REQ-010 SHALL have port instr_valid  output  1  instr/instr_pc valid.
REQ-011 SHALL have port instr_ready  input  1  decoder consumes head this cycle.
REQ-012 SHALL have port br_taken  input  1  redirect request from the control path, qualified by consume.
REQ-013 SHALL have port br_target  input  32  redirect address; bits[1:0] ignored (treated as 00).

Function
REQ-014 SHALL hold fetch_pc register, 2-entry instruction FIFO (instr + pc per entry), count 0..2, FSM {S_REQ, S_WAIT, S_DROP}.
REQ-015 SHALL define consume = instr_valid & instr_ready; flush = consume & br_taken.
REQ-016 SHALL assert instr_valid exactly when count != 0; instr/instr_pc SHALL be the head entry, registered (no bypass from im_rdata).
REQ-017 SHALL keep at most one memory request outstanding.
REQ-018 S_REQ: SHALL assert im_req with im_addr = fetch_pc when count_next <= 1 and no flush; on issue fetch_pc += 4, state -> S_WAIT.
REQ-019 S_WAIT, im_rvalid, no flush: SHALL push {im_rdata, pc of request}; if count_next <= 1 SHALL issue next request same cycle (stay S_WAIT), else -> S_REQ.
REQ-020 count_next SHALL include this cycle's push and pop; push and pop in same cycle leave count unchanged.
REQ-021 SHALL never push when FIFO full; issue rule REQ-018/019 guarantees a slot for every outstanding response.
REQ-022 flush SHALL clear FIFO (count -> 0, overriding any same-cycle push), set fetch_pc = {br_target[31:2], 2'b00}, suppress im_req that cycle.
REQ-023 flush in S_REQ -> S_REQ; in S_WAIT without im_rvalid -> S_DROP; in S_WAIT with im_rvalid -> S_REQ, response discarded.
REQ-024 S_DROP: SHALL discard next im_rvalid and -> S_REQ; no im_req while in S_DROP; further flush in S_DROP stays S_DROP with new target.
REQ-025 PC arithmetic SHALL be modulo 2^32 (0xFFFF_FFFC + 4 wraps to 0x0000_0000).
REQ-026 br_taken without consume SHALL have no effect.
REQ-027 With 1-cycle memory and instr_ready held high, SHALL sustain one instruction per cycle after initial fill; first instr_valid 3 cycles after rst deasserts.

Reset
REQ-028 While rst high: im_req=0, instr_valid=0, count=0, fetch_pc=RESET_PC, state=S_REQ, instr/instr_pc=0; in-flight responses arriving during rst SHALL be ignored.
REQ-029 Reset mid-operation SHALL abandon any outstanding request; first im_req SHALL appear in first cycle after rst deasserts with im_addr=RESET_PC.

Verification
REQ-030 Reset release, 1-cycle memory, instr_ready=1 -> im_addr 0x0,0x4,0x8 on consecutive cycles; instr_pc 0x0,0x4,0x8 back-to-back from cycle 3.
REQ-031 instr_ready=0 for 10 cycles -> count saturates at 2, im_req stops, no data lost; release -> pcs 0x0,0x4,0x8 in order.
REQ-032 Consume of pc 0x4 with br_taken=1, br_target=0x103 while request for 0xC outstanding -> 0xC response dropped, next im_addr=0x100, next instr_pc=0x100.
REQ-033 Flush same cycle as im_rvalid -> response discarded, im_req 0x(target) next cycle, instr_valid low until its data returns.
REQ-034 RESET_PC=0xFFFF_FFF8 -> im_addr sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-035 Assert rst in S_WAIT, memory returns data during/after reset -> data ignored, instr_valid=0, restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: keeps one memory read in flight and buffers up to two
// fetched instructions (with their PCs) ahead of the decoder.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [1:0]  dbg_state_o,
    output logic [1:0]  dbg_count_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    localparam logic [31:0] PC_MASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_ADDR = RESET_PC & PC_MASK;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] tail_instr_q, tail_instr_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic [1:0]  count_q, count_d;
    logic        valid_q, valid_d;

    logic        consume;
    logic        flush;
    logic        rsp;
    logic        issue;
    logic [1:0]  count_next;
    logic [1:0]  wr_slot;

    // Decoder handshake: the head entry transfers in any cycle where
    // instr_valid and instr_ready are both high; br_taken only counts then.
    assign consume = valid_q & instr_ready;
    assign flush   = consume & br_taken;
    assign rsp     = (state_q == S_WAIT) & im_rvalid;

    assign count_next = count_q + {1'b0, rsp} - {1'b0, consume};
    assign wr_slot    = count_q - {1'b0, consume};

    // A new read may only go out when its response is guaranteed a slot.
    assign issue = ~flush & (count_next <= 2'd1) &
                   ((state_q == S_REQ) | rsp);

    assign im_req      = issue & ~rst;
    assign im_addr     = fetch_pc_q;
    assign instr       = head_instr_q;
    assign instr_pc    = head_pc_q;
    assign instr_valid = valid_q;
    assign dbg_state_o = state_q;
    assign dbg_count_o = count_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        count_d      = count_q;

        if (flush) begin
            count_d    = 2'd0;
            fetch_pc_d = br_target & PC_MASK;
            case (state_q)
                S_WAIT:  state_d = im_rvalid ? S_REQ : S_DROP;
                S_DROP:  state_d = im_rvalid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            count_d = count_next;

            if (consume) begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
            end

            if (rsp) begin
                if (wr_slot == 2'd0) begin
                    head_instr_d = im_rdata;
                    head_pc_d    = req_pc_q;
                end else begin
                    tail_instr_d = im_rdata;
                    tail_pc_d    = req_pc_q;
                end
            end

            if (issue) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end

            case (state_q)
                S_REQ:   state_d = issue ? S_WAIT : S_REQ;
                S_WAIT:  state_d = im_rvalid ? (issue ? S_WAIT : S_REQ) : S_WAIT;
                S_DROP:  state_d = im_rvalid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end

        valid_d = (count_d != 2'd0);
    end

    // Reset drops any read still in flight: S_REQ ignores im_rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_ADDR;
            req_pc_q     <= 32'h0;
            head_instr_q <= 32'h0;
            head_pc_q    <= 32'h0;
            tail_instr_q <= 32'h0;
            tail_pc_q    <= 32'h0;
            count_q      <= 2'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
        end
    end

endmodule
